alu_uart_if: RTL

ALU_UART_IF -- requirements
Module: alu_uart_if

---
 rtl/alu_uart_if.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_uart_if.sv
// alu_uart_if
// Glue between a byte-wide UART and a combinational ALU. Collects a
// three-byte frame (operand A, operand B, opcode), presents the operands
// and opcode to the ALU, captures the ALU result and hands it to the UART
// transmitter. Rejects unknown opcodes, aborts stalled frames after an
// inter-byte timeout and flags bytes that arrive while a result is in
// flight.
//
// Ports
//   i_clk, i_reset_n         clock, async active-low reset
//   i_rx_data, i_rx_done     received byte + one-cycle strobe
//   o_dato_a, o_dato_b       registered operands to ALU
//   o_op_code                registered opcode to ALU
//   i_resultado              combinational ALU result
//   o_tx_data, o_tx_start    byte + one-cycle start strobe to transmitter
//   i_tx_done                transmitter finished strobe
//   o_err_opcode             one-cycle pulse, invalid opcode rejected
//   o_err_timeout            one-cycle pulse, frame aborted by timeout
//   o_overrun                sticky, byte received while transmitting
//   o_busy                   high whenever a frame is in progress
//
// state  | meaning
// -------+------------------------------------------------------------
// S_A    | idle, waiting for operand A
// S_B    | waiting for operand B (timeout armed)
// S_OP   | waiting for opcode (timeout armed)
// S_EXEC | one cycle: capture ALU result, launch transmission
// S_TX   | waiting for transmitter to finish
module alu_uart_if #(
   parameter int OPERAND_SIZE   = 8,
   parameter int OP_CODE_SIZE   = 6,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic [OPERAND_SIZE-1:0] i_rx_data,
   input  logic                    i_rx_done,
   output logic [OPERAND_SIZE-1:0] o_dato_a,
   output logic [OPERAND_SIZE-1:0] o_dato_b,
   output logic [OP_CODE_SIZE-1:0] o_op_code,
   input  logic [OPERAND_SIZE-1:0] i_resultado,
   output logic [OPERAND_SIZE-1:0] o_tx_data,
   output logic                    o_tx_start,
   input  logic                    i_tx_done,
   output logic                    o_err_opcode,
   output logic                    o_err_timeout,
   output logic                    o_overrun,
   output logic                    o_busy
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [OP_CODE_SIZE-1:0] OP_ADD = OP_CODE_SIZE'(32'h20);
   localparam logic [OP_CODE_SIZE-1:0] OP_SUB = OP_CODE_SIZE'(32'h22);
   localparam logic [OP_CODE_SIZE-1:0] OP_AND = OP_CODE_SIZE'(32'h24);
   localparam logic [OP_CODE_SIZE-1:0] OP_OR  = OP_CODE_SIZE'(32'h25);
   localparam logic [OP_CODE_SIZE-1:0] OP_XOR = OP_CODE_SIZE'(32'h26);
   localparam logic [OP_CODE_SIZE-1:0] OP_SRA = OP_CODE_SIZE'(32'h03);
   localparam logic [OP_CODE_SIZE-1:0] OP_SRL = OP_CODE_SIZE'(32'h02);
   localparam logic [OP_CODE_SIZE-1:0] OP_NOR = OP_CODE_SIZE'(32'h27);
   localparam logic [OP_CODE_SIZE-1:0] OP_RST = OP_CODE_SIZE'(32'h00);

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_OP   = 3'd2,
      S_EXEC = 3'd3,
      S_TX   = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [OPERAND_SIZE-1:0] dato_a_q, dato_a_d;
   logic [OPERAND_SIZE-1:0] dato_b_q, dato_b_d;
   logic [OP_CODE_SIZE-1:0] op_code_q, op_code_d;
   logic [OPERAND_SIZE-1:0] tx_data_q, tx_data_d;
   logic                    tx_start_q, tx_start_d;
   logic                    err_opcode_q, err_opcode_d;
   logic                    err_timeout_q, err_timeout_d;
   logic                    overrun_q, overrun_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   logic [OP_CODE_SIZE-1:0] rx_op;
   logic                    op_valid;
   logic                    cnt_expired;

   // Bits of the received byte above the opcode field are ignored.
   assign rx_op       = i_rx_data[OP_CODE_SIZE-1:0];
   assign cnt_expired = (cnt_q == CNT_LAST);

   always_comb begin
      op_valid = 1'b0;
      case (rx_op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
         OP_SRA, OP_SRL, OP_NOR, OP_RST: op_valid = 1'b1;
         default:                        op_valid = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q       <= S_A;
         dato_a_q      <= '0;
         dato_b_q      <= '0;
         op_code_q     <= '0;
         tx_data_q     <= '0;
         tx_start_q    <= 1'b0;
         err_opcode_q  <= 1'b0;
         err_timeout_q <= 1'b0;
         overrun_q     <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         dato_a_q      <= dato_a_d;
         dato_b_q      <= dato_b_d;
         op_code_q     <= op_code_d;
         tx_data_q     <= tx_data_d;
         tx_start_q    <= tx_start_d;
         err_opcode_q  <= err_opcode_d;
         err_timeout_q <= err_timeout_d;
         overrun_q     <= overrun_d;
         cnt_q         <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      dato_a_d      = dato_a_q;
      dato_b_d      = dato_b_q;
      op_code_d     = op_code_q;
      tx_data_d     = tx_data_q;
      tx_start_d    = 1'b0;
      err_opcode_d  = 1'b0;
      err_timeout_d = 1'b0;
      overrun_d     = overrun_q;
      cnt_d         = cnt_q;

      case (state_q)
         S_A: begin
            cnt_d = '0;
            if (i_rx_done) begin
               dato_a_d = i_rx_data;
               state_d  = S_B;
            end
         end

         // A byte arriving on the expiry cycle wins over the timeout.
         S_B: begin
            if (i_rx_done) begin
               dato_b_d = i_rx_data;
               cnt_d    = '0;
               state_d  = S_OP;
            end else if (cnt_expired) begin
               cnt_d         = '0;
               err_timeout_d = 1'b1;
               state_d       = S_A;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_OP: begin
            if (i_rx_done) begin
               cnt_d = '0;
               if (op_valid) begin
                  op_code_d = rx_op;
                  state_d   = S_EXEC;
               end else begin
                  err_opcode_d = 1'b1;
                  state_d      = S_A;
               end
            end else if (cnt_expired) begin
               cnt_d         = '0;
               err_timeout_d = 1'b1;
               state_d       = S_A;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         // Operands and opcode are already registered, so the ALU result
         // is settled during this single cycle.
         S_EXEC: begin
            tx_data_d  = i_resultado;
            tx_start_d = 1'b1;
            state_d    = S_TX;
            if (i_rx_done) begin
               overrun_d = 1'b1;
            end
         end

         S_TX: begin
            if (i_rx_done) begin
               overrun_d = 1'b1;
            end
            if (i_tx_done) begin
               state_d = S_A;
            end
         end

         default: begin
            cnt_d   = '0;
            state_d = S_A;
         end
      endcase
   end

   assign o_dato_a      = dato_a_q;
   assign o_dato_b      = dato_b_q;
   assign o_op_code     = op_code_q;
   assign o_tx_data     = tx_data_q;
   assign o_tx_start    = tx_start_q;
   assign o_err_opcode  = err_opcode_q;
   assign o_err_timeout = err_timeout_q;
   assign o_overrun     = overrun_q;
   assign o_busy        = (state_q != S_A);

endmodule
